// File: rtl/a7_bus_pkg.sv
// rtl/a7_bus_pkg.sv - shared constants, state encoding and frame helper for the A7 serial bus master
package a7_bus_pkg;

    localparam logic [7:0] OP_RD      = 8'h01;
    localparam logic [7:0] OP_WR      = 8'h02;
    localparam int         FRAME_BITS = 12;
    localparam int         CMD_BYTES  = 5;
    localparam logic [7:0] TO_STATUS  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_t;

    // Line format, MSB first: two leading zeros, start bit, flag, data byte.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic flag, input logic [7:0] data);
        return {2'b00, 1'b1, flag, data};
    endfunction

endpackage

// File: rtl/a7_rx_frame.sv
// rtl/a7_rx_frame.sv - serial frame receiver: input register, 12-bit shifter and accept detect
module a7_rx_frame
    import a7_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       flag
);

    logic                  ser_q;
    logic [FRAME_BITS-1:0] shreg;

    // The start bit reaches the top once the next two zero bits (gap or the
    // following frame's leading zeros) are already shifted in behind d0.
    assign byte_valid = shreg[FRAME_BITS-1] & ~shreg[1] & ~shreg[0];
    assign rx_byte    = shreg[9:2];
    assign flag       = shreg[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_q <= 1'b0;
            shreg <= '0;
        end else begin
            ser_q <= ser_in;
            if (byte_valid)
                shreg <= {{(FRAME_BITS-1){1'b0}}, ser_q};
            else
                shreg <= {shreg[FRAME_BITS-2:0], ser_q};
        end
    end

endmodule

// File: rtl/a7_bus_master.sv
// rtl/a7_bus_master.sv - serial register-transaction sequencer; A7_BUS_MASTER_STATS_EN adds frame counters
module a7_bus_master
    import a7_bus_pkg::*;
#(
    parameter int GAP     = 4,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wrdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_status,
    output logic [15:0] rsp_rddata,
    output logic        busy,
`ifdef A7_BUS_MASTER_STATS_EN
    output logic [15:0] stat_tx,
    output logic [15:0] stat_rx,
    output logic [15:0] stat_timeouts,
    output logic [15:0] stat_stray,
`endif
    output logic        ser_out,
    input  logic        ser_in
);

    localparam int SLOT = FRAME_BITS + GAP;
    localparam int BW   = $clog2(SLOT);

    state_t                state;
    logic [2:0]            byte_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [TW-1:0]         to_cnt;
    logic                  wr_q;
    logic [15:0]           addr_q;
    logic [15:0]           wd_q;
    // Only the low three response bytes are ever reported, so older bytes
    // (and missing ones, which read as zero) need no storage.
    logic [23:0]           word;
    logic [23:0]           next_word;
    logic [7:0]            cur_byte;
    logic [FRAME_BITS-1:0] frame_sh;
    logic                  tx_bit;
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_flag;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    a7_rx_frame u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .flag       (rx_flag)
    );

    always_comb begin
        cur_byte = 8'h00;
        case (byte_cnt)
            3'd0:    cur_byte = wr_q ? OP_WR : OP_RD;
            3'd1:    cur_byte = addr_q[15:8];
            3'd2:    cur_byte = addr_q[7:0];
            3'd3:    cur_byte = wr_q ? wd_q[15:8] : 8'h00;
            default: cur_byte = wr_q ? wd_q[7:0] : 8'h00;
        endcase
        // Shifting past the frame length yields the zero gap bits for free.
        frame_sh  = make_frame(byte_cnt == 3'(CMD_BYTES-1), cur_byte) << bit_cnt;
        tx_bit    = frame_sh[FRAME_BITS-1];
        next_word = {word[15:0], rx_byte};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            word       <= '0;
            ser_out    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_status <= '0;
            rsp_rddata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ser_out <= 1'b0;
                    if (req_valid) begin
                        wr_q     <= req_wr;
                        addr_q   <= req_addr;
                        wd_q     <= req_wrdata;
                        word     <= '0;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    ser_out <= tx_bit;
                    if (bit_cnt == BW'(SLOT-1)) begin
                        bit_cnt <= '0;
                        if (byte_cnt == 3'(CMD_BYTES-1)) begin
                            to_cnt <= '0;
                            state  <= WAIT;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    ser_out <= 1'b0;
                    if (rx_valid)
                        word <= next_word;
                    // A flagged frame takes priority over a coincident timeout.
                    if (rx_valid && rx_flag) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        rsp_status <= next_word[7:0];
                        rsp_rddata <= next_word[23:8];
                    end else if (to_cnt == TW'(TIMEOUT)) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                        rsp_status <= TO_STATUS;
                        rsp_rddata <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    ser_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef A7_BUS_MASTER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tx       <= '0;
            stat_rx       <= '0;
            stat_timeouts <= '0;
            stat_stray    <= '0;
        end else begin
            if (state == SEND && bit_cnt == BW'(FRAME_BITS-1))
                stat_tx <= stat_tx + 16'd1;
            if (rx_valid)
                stat_rx <= stat_rx + 16'd1;
            if (rx_valid && state != WAIT)
                stat_stray <= stat_stray + 16'd1;
            if (state == WAIT && !(rx_valid && rx_flag) && to_cnt == TW'(TIMEOUT))
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_a7_bus_master.sv
// tb/tb_a7_bus_master.sv - self-checking bench for a7_bus_master
module tb_a7_bus_master;
    import a7_bus_pkg::*;

    localparam int GAP     = 4;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wrdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_status;
    logic [15:0] rsp_rddata;
    logic        busy;
    logic        ser_out;
    logic        ser_in = 1'b0;
`ifdef A7_BUS_MASTER_STATS_EN
    logic [15:0] stat_tx, stat_rx, stat_timeouts, stat_stray;
`endif

    logic        mon_valid;
    logic [7:0]  mon_byte;
    logic        mon_flag;
    logic [11:0] tx_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int rsp_cnt = 0;
    int hs_cnt = 0;

    typedef struct {
        logic            wr;
        logic [15:0]     addr;
        logic [15:0]     wd;
        int              nb;
        logic [0:6][7:0] rb;
        logic            eerr;
        logic [7:0]      est;
        logic [15:0]     erd;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    a7_bus_master #(.GAP(GAP), .TIMEOUT(TIMEOUT), .TW(13)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wrdata (req_wrdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_status (rsp_status),
        .rsp_rddata (rsp_rddata),
        .busy       (busy),
`ifdef A7_BUS_MASTER_STATS_EN
        .stat_tx       (stat_tx),
        .stat_rx       (stat_rx),
        .stat_timeouts (stat_timeouts),
        .stat_stray    (stat_stray),
`endif
        .ser_out    (ser_out),
        .ser_in     (ser_in)
    );

    // Spartan6-side view of the command line.
    a7_rx_frame u_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_out),
        .byte_valid (mon_valid),
        .rx_byte    (mon_byte),
        .flag       (mon_flag)
    );

    always @(posedge clk) begin
        if (mon_valid) tx_q.push_back({3'b001, mon_flag, mon_byte});
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_frame(input vec_t v, input int i);
        logic [7:0] b;
        case (i)
            0:       b = v.wr ? 8'h02 : 8'h01;
            1:       b = v.addr[15:8];
            2:       b = v.addr[7:0];
            3:       b = v.wr ? v.wd[15:8] : 8'h00;
            default: b = v.wr ? v.wd[7:0] : 8'h00;
        endcase
        return {3'b001, (i == 4), b};
    endfunction

    task automatic send_frame(input logic flag, input logic [7:0] data);
        logic [11:0] f;
        f = {3'b001, flag, data};
        for (int i = 11; i >= 0; i--) begin
            @(negedge clk);
            ser_in = f[i];
        end
        repeat (GAP) begin
            @(negedge clk);
            ser_in = 1'b0;
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int base_rsp;
        int k;
        base_rsp = rsp_cnt;
        tx_q.delete();
        @(negedge clk);
        req_wr = v.wr; req_addr = v.addr; req_wrdata = v.wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, " busy after handshake"}, busy, 1'b1);
        k = 0;
        while (tx_q.size() < 5 && k < 300) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, " frame count"}, tx_q.size(), 5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++)
            chk($sformatf("%s frame %0d", tag, i), tx_q[i], exp_frame(v, i));
        repeat (20) @(negedge clk);
        for (int j = 0; j < v.nb; j++)
            send_frame(j == v.nb - 1, v.rb[j]);
        k = 0;
        while (rsp_cnt == base_rsp && k < 200) begin
            @(posedge clk); #1; k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " rsp pulses"}, rsp_cnt - base_rsp, 1);
        chk({tag, " err"}, rsp_err, v.eerr);
        chk({tag, " status"}, rsp_status, v.est);
        chk({tag, " rddata"}, rsp_rddata, v.erd);
        chk({tag, " ready after done"}, req_ready, 1'b1);
    endtask

    initial begin
        int n;
        int base_hs, base_rsp, rises, done_seen;
        logic prev_ready;

        vecs[0] = '{wr:1'b1, addr:16'h0003, wd:16'h1234, nb:1, rb:56'h00000000000000,
                    eerr:1'b0, est:8'h00, erd:16'h0000};
        vecs[1] = '{wr:1'b0, addr:16'h0001, wd:16'h0000, nb:5, rb:56'h0000BEEF000000,
                    eerr:1'b0, est:8'h00, erd:16'hBEEF};
        vecs[2] = '{wr:1'b0, addr:16'h8A5C, wd:16'hFFFF, nb:2, rb:56'h5AC30000000000,
                    eerr:1'b0, est:8'hC3, erd:16'h005A};
        vecs[3] = '{wr:1'b1, addr:16'hFFFF, wd:16'hA5A5, nb:7, rb:56'h11223344556677,
                    eerr:1'b0, est:8'h77, erd:16'h5566};

        #23;
        chk("reset ser_out", ser_out, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset req_ready", req_ready, 1'b1);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_err", rsp_err, 1'b0);
        chk("reset rsp_status", rsp_status, 8'h00);
        chk("reset rsp_rddata", rsp_rddata, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray flagged frame while idle must be dropped.
        send_frame(1'b1, 8'hA5);
        repeat (30) @(posedge clk);
        #1;
        chk("stray rsp pulses", rsp_cnt, 0);
        chk("stray busy", busy, 1'b0);
        chk("stray status", rsp_status, 8'h00);
`ifdef A7_BUS_MASTER_STATS_EN
        chk("stat_stray", stat_stray, 16'd1);
`endif

        for (int i = 0; i < 4; i++)
            do_txn(vecs[i], $sformatf("vec%0d", i));

        // Silent responder: timeout latency measured from the handshake edge.
        @(negedge clk);
        req_wr = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 6000) begin
            @(posedge clk); #1; n++;
            if (n == 100) chk("hold status in WAIT", rsp_status, 8'h77);
        end
        chk("timeout latency", n, 5 * (12 + GAP) + TIMEOUT + 1);
        chk("timeout err", rsp_err, 1'b1);
        chk("timeout status", rsp_status, 8'hFF);
        chk("timeout rddata", rsp_rddata, 16'h0000);
        @(posedge clk); #1;
        chk("timeout pulse width", rsp_valid, 1'b0);

        // req_valid held high across three silent transactions.
        base_hs = hs_cnt; base_rsp = rsp_cnt; rises = 0; done_seen = 0;
        @(negedge clk);
        req_wr = 1'b0; req_addr = 16'h0042; req_valid = 1'b1;
        prev_ready = req_ready;
        n = 0;
        while (done_seen < 3 && n < 15000) begin
            @(posedge clk); #1; n++;
            if (req_ready && !prev_ready) begin
                rises++;
                chk("b2b ready rise after rsp", rsp_cnt - base_rsp, hs_cnt - base_hs);
            end
            prev_ready = req_ready;
            if (rsp_valid) done_seen++;
        end
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b completions", done_seen, 3);
        chk("b2b handshakes", hs_cnt - base_hs, 3);
        chk("b2b rsp pulses", rsp_cnt - base_rsp, 3);
        chk("b2b ready rises", rises, 2);

        // Reset asserted mid-SEND on a '1' data bit of byte 2.
        @(negedge clk);
        req_wr = 1'b1; req_addr = 16'h00FF; req_wrdata = 16'h0000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        chk("mid-send ser_out high", ser_out, 1'b1);
        chk("mid-send busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset ser_out", ser_out, 1'b0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset ready", req_ready, 1'b1);
        chk("async reset status", rsp_status, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn(vecs[1], "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
